// File: rtl/ram_sync.sv
// Synchronous single-port RAM with req/rdy handshake, registered read data + vld,
// and a clear sequencer that zeroes every word. Optional parity: define RAM_PARITY_EN.
module ram_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             rws,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] ins,
  input  logic             clr,
  output logic             rdy,
  output logic [WIDTH-1:0] outs,
  output logic             vld
`ifdef RAM_PARITY_EN
  ,
  output logic             perr
`endif
);

`ifdef RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  logic [MW-1:0]    mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] outs_q, outs_d;
  logic             vld_q, vld_d;
`ifdef RAM_PARITY_EN
  logic             perr_q, perr_d;
`endif

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [MW-1:0]    mem_wdata;
  logic [MW-1:0]    rd_word;
  logic             in_range;

  // Only non-power-of-two depths can present an address past the last word.
  assign in_range = ({1'b0, addr} < DEPTH_EXT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    outs_d    = outs_q;
    vld_d     = 1'b0;
`ifdef RAM_PARITY_EN
    perr_d    = 1'b0;
`endif
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    rd_word   = '0;

    if (clr) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      outs_d  = '0;
    end else if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      if (cnt_q == LAST) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (req) begin
      if (rws) begin
        if (in_range) begin
          mem_we    = 1'b1;
          mem_waddr = addr;
`ifdef RAM_PARITY_EN
          mem_wdata = {^ins, ins};
`else
          mem_wdata = ins;
`endif
        end
      end else begin
        vld_d = 1'b1;
        if (in_range) begin
          rd_word = mem[addr];
          outs_d  = rd_word[WIDTH-1:0];
`ifdef RAM_PARITY_EN
          // Stored word (data + parity) must have even overall parity.
          perr_d  = ^rd_word;
`endif
        end else begin
          outs_d = '0;
        end
      end
    end

    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      outs_q  <= '0;
      vld_q   <= 1'b0;
`ifdef RAM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
      vld_q   <= vld_d;
`ifdef RAM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rdy  = (state_q == ST_RUN);
  assign outs = outs_q;
  assign vld  = vld_q;
`ifdef RAM_PARITY_EN
  assign perr = perr_q;
`endif

endmodule

// File: tb/tb_ram_sync.sv
// Drives an 8x8 and a 16x6 ram_sync with one shared stimulus stream and checks
// both against a per-instance behavioural model (word array + sweep countdown).
module tb_ram_sync;

  logic        clk;
  logic        rst, clr, req, rws;
  logic [2:0]  addr;
  logic [15:0] ins;

  logic        rdy8, vld8, rdy6, vld6;
  logic [7:0]  outs8;
  logic [15:0] outs6;
`ifdef RAM_PARITY_EN
  logic        perr8, perr6;
`endif

  int checks   = 0;
  int failures = 0;

  ram_sync #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .req(req), .rws(rws), .addr(addr), .ins(ins[7:0]),
    .clr(clr), .rdy(rdy8), .outs(outs8), .vld(vld8)
`ifdef RAM_PARITY_EN
    , .perr(perr8)
`endif
  );

  ram_sync #(.WIDTH(16), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .req(req), .rws(rws), .addr(addr), .ins(ins),
    .clr(clr), .rdy(rdy6), .outs(outs6), .vld(vld6)
`ifdef RAM_PARITY_EN
    , .perr(perr6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, index 0 = 8x8 instance, index 1 = 16x6 instance.
  int          dep [2] = '{8, 6};
  int          sweep_left [2];
  logic [15:0] mm [2][8];
  logic        flip [2][8];
  logic [15:0] exp_outs [2];
  logic        exp_vld [2];
  logic        exp_perr [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_edge(input int d, input logic r, input logic c, input logic q,
                            input logic w, input logic [2:0] a, input logic [15:0] di);
    logic [15:0] mk;
    mk = (d == 0) ? 16'h00FF : 16'hFFFF;
    exp_vld[d]  = 1'b0;
    exp_perr[d] = 1'b0;
    if (r || c) begin
      sweep_left[d] = dep[d];
      exp_outs[d]   = '0;
    end else if (sweep_left[d] > 0) begin
      sweep_left[d]--;
      if (sweep_left[d] == 0) begin
        for (int i = 0; i < 8; i++) begin
          mm[d][i]   = '0;
          flip[d][i] = 1'b0;
        end
      end
    end else if (q) begin
      if (w) begin
        if (int'(a) < dep[d]) begin
          mm[d][a]   = di & mk;
          flip[d][a] = 1'b0;
        end
      end else begin
        exp_vld[d] = 1'b1;
        if (int'(a) < dep[d]) begin
          exp_outs[d] = mm[d][a];
          exp_perr[d] = flip[d][a];
        end else begin
          exp_outs[d] = '0;
        end
      end
    end
  endtask

  // One clock edge: apply inputs, advance models, sample 1ns after the edge.
  task automatic tick(input string tag, input logic r, input logic c, input logic q,
                      input logic w, input logic [2:0] a, input logic [15:0] di);
    rst = r; clr = c; req = q; rws = w; addr = a; ins = di;
    @(posedge clk);
    model_edge(0, r, c, q, w, a, di);
    model_edge(1, r, c, q, w, a, di);
    #1;
    check_eq({tag, ".rdy8"},  32'(rdy8),  32'(sweep_left[0] == 0));
    check_eq({tag, ".vld8"},  32'(vld8),  32'(exp_vld[0]));
    check_eq({tag, ".outs8"}, 32'(outs8), 32'(exp_outs[0][7:0]));
    check_eq({tag, ".rdy6"},  32'(rdy6),  32'(sweep_left[1] == 0));
    check_eq({tag, ".vld6"},  32'(vld6),  32'(exp_vld[1]));
    check_eq({tag, ".outs6"}, 32'(outs6), 32'(exp_outs[1]));
`ifdef RAM_PARITY_EN
    check_eq({tag, ".perr8"}, 32'(perr8), 32'(exp_perr[0]));
    check_eq({tag, ".perr6"}, 32'(perr6), 32'(exp_perr[1]));
`endif
    $display("tick %-8s rst=%0b clr=%0b req=%0b rws=%0b addr=%0d ins=%h | rdy8=%0b vld8=%0b outs8=%h rdy6=%0b vld6=%0b outs6=%h",
             tag, r, c, q, w, a, di, rdy8, vld8, outs8, rdy6, vld6, outs6);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = 1'b0; rws = 1'b0; addr = '0; ins = '0;
    for (int d = 0; d < 2; d++) begin
      sweep_left[d] = dep[d];
      exp_outs[d]   = '0;
      exp_vld[d]    = 1'b0;
      exp_perr[d]   = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mm[d][i]   = '0;
        flip[d][i] = 1'b0;
      end
    end

    // Reset held two cycles, then the sweep; rdy8 must rise on the 8th edge.
    tick("rst", 1, 0, 0, 0, 0, 0);
    tick("rst", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick("sweep", 0, 0, 0, 0, 0, 0);
    check_eq("rdy8_after_sweep", 32'(rdy8), 32'd1);

    tick("rd5", 0, 0, 1, 0, 3'd5, 0);
    check_eq("rd5_outs", 32'(outs8), 32'h00);
    tick("idle", 0, 0, 0, 0, 0, 0);

    tick("wr3", 0, 0, 1, 1, 3'd3, 16'h00A5);
    tick("wr7", 0, 0, 1, 1, 3'd7, 16'h003C);
    tick("rd3", 0, 0, 1, 0, 3'd3, 0);
    check_eq("rd3_outs", 32'(outs8), 32'hA5);
    tick("rd7", 0, 0, 1, 0, 3'd7, 0);
    check_eq("rd7_outs", 32'(outs8), 32'h3C);
    tick("wr3b", 0, 0, 1, 1, 3'd3, 16'h00A5);
    tick("rd3b", 0, 0, 1, 0, 3'd3, 0);
    check_eq("wr_rd3_outs", 32'(outs8), 32'hA5);

    // clr beats a simultaneous write; sweep restarts.
    tick("clr", 0, 1, 1, 1, 3'd0, 16'h00FF);
    for (int i = 0; i < 8; i++) tick("csweep", 0, 0, 0, 0, 0, 0);
    tick("rd3c", 0, 0, 1, 0, 3'd3, 0);
    check_eq("clr_rd3", 32'(outs8), 32'h00);
    tick("rd0c", 0, 0, 1, 0, 3'd0, 0);
    check_eq("clr_rd0", 32'(outs8), 32'h00);

    // Out-of-range on the 6-deep instance.
    tick("wr6", 0, 0, 1, 1, 3'd6, 16'h1234);
    tick("rd6", 0, 0, 1, 0, 3'd6, 0);
    check_eq("oob_outs6", 32'(outs6), 32'h0000);
    check_eq("oob_vld6",  32'(vld6),  32'd1);

    // Requests while sweeping are dropped.
    tick("clr2", 0, 1, 0, 0, 0, 0);
    tick("rdsw", 0, 0, 1, 0, 3'd1, 0);
    check_eq("sweep_rd_vld8", 32'(vld8), 32'd0);
    tick("wrsw", 0, 0, 1, 1, 3'd1, 16'hBEEF);
    for (int i = 0; i < 8; i++) tick("sweep2", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic r, c;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 49) == 0);
      tick("rand", r, c, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 16'($urandom));
    end

`ifdef RAM_PARITY_EN
    for (int i = 0; i < 10; i++) tick("psweep", 0, 1 && (i == 0), 0, 0, 0, 0);
    tick("pwr2", 0, 0, 1, 1, 3'd2, 16'h000F);
    u_dut8.mem[2][8] = ~u_dut8.mem[2][8];
    flip[0][2] = 1'b1;
    tick("prd2", 0, 0, 1, 0, 3'd2, 0);
    check_eq("par_outs8", 32'(outs8), 32'h0F);
    check_eq("par_perr8", 32'(perr8), 32'd1);
    tick("prd4", 0, 0, 1, 0, 3'd4, 0);
    check_eq("par_clean", 32'(perr8), 32'd0);
`endif

    tick("end", 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_sync.md
# ram_sync

Parametrised synchronous single-port RAM with a request/ready handshake, one-cycle registered read data with a valid strobe, and a hardware clear sequencer that zeroes every word after reset or on demand. It is the clocked, width/depth-generalised successor to the team's 8x8 gate-level RAM. It serves as the storage element for register-file and scratchpad users in the datapath.

## Interface
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 8, number of words (≥2; need not be a power of two).
- AW, $clog2(DEPTH), address width; derived localparam, not overridable.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  access request; accepted on a rising edge where req=1 and rdy=1.
- rws  input  1  access type: 1 = write, 0 = read.
- addr  input  AW  word address.
- ins  input  WIDTH  write data.
- clr  input  1  start a zeroing sweep of the whole array.
- rdy  output  1  array is ready to accept req; 0 while sweeping.
- outs  output  WIDTH  registered read data.
- vld  output  1  one-cycle pulse: outs holds data from an accepted read.
- perr  output  1  parity error on the read now presented; present only with RAM_PARITY_EN.

## Operation
- Two states: INIT (sweeping) and RUN.
- Reset (rst=1 at an edge): state=INIT, sweep counter cnt=0, rdy=0, vld=0, outs=0, perr=0. The array is not written while rst=1.
- INIT: each edge with rst=0 writes all-zeros to mem[cnt] and increments cnt. The edge that writes cnt=DEPTH-1 moves the block to RUN and sets rdy=1.
- RUN, accepted write: mem[addr] <= ins. outs is unchanged and vld=0.
- RUN, accepted read: outs <= mem[addr] and vld <= 1 on the same edge. vld deasserts on the next edge unless another read is accepted.
- outs holds its last read value until the next accepted read, reset, or clr; it is never cleared by writes.
- Out-of-range address (addr ≥ DEPTH, only possible for non-power-of-two DEPTH):
  - write is discarded;
  - read returns all-zeros with vld=1.
- clr=1 at an edge in RUN: enter INIT with cnt=0, rdy=0, outs=0, vld=0. A req in the same cycle is ignored, so clr wins.
- clr=1 during INIT restarts the sweep at cnt=0.
- rst has priority over clr and req.
- A req while rdy=0 is dropped silently: no write, no vld. The requester must hold req until it sees rdy=1.

## Timing
- Sweep length: rdy rises exactly DEPTH edges after the first edge with rst=0 (or after the clr edge, which itself counts as the restart edge; rdy rises DEPTH edges later).
- Read latency: 1 cycle. Request at edge N; outs and vld are valid after edge N and sampled at edge N+1.
- Throughput: one access per cycle; back-to-back reads produce a continuous vld.
- Write-then-read to the same address on consecutive edges returns the newly written data.
- No combinational path from any input to any output.

## Configuration
- RAM_PARITY_EN defined:
  - each word stores an extra even-parity bit (^ins) on write;
  - the sweep stores parity 0;
  - on an accepted read, perr is registered with vld and set to 1 when the recomputed parity mismatches;
  - perr follows the same reset, clr and one-cycle-pulse rules as vld;
  - out-of-range reads give perr=0.
- RAM_PARITY_EN undefined: no parity storage, no perr port, array is exactly DEPTH×WIDTH.

## Test plan
- Reset release, DEPTH=8: rst high 2 cycles then low → rdy=0 for 8 edges, then rdy=1; outs=0x00 and vld=0 throughout.
- Post-sweep read: read addr 5 → next cycle outs=0x00, vld=1 for one cycle.
- Write then read:
  - write 0xA5 to addr 3, then 0x3C to addr 7;
  - read 3 and 7 back-to-back → outs=0xA5 then 0x3C, vld high 2 consecutive cycles;
  - an immediate read of addr 3 directly after its write also returns 0xA5.
- clr mid-run:
  - after the writes above, assert clr together with a write of 0xFF to addr 0 → write ignored, rdy=0 for 8 edges;
  - reading addr 3 and addr 0 afterwards returns 0x00.
- Edge handling with WIDTH=16, DEPTH=6:
  - write 0x1234 to addr 6 → discarded;
  - read addr 6 → outs=0x0000, vld=1;
  - req with rdy=0 during the sweep → no vld.
- RAM_PARITY_EN:
  - write 0x0F to addr 2;
  - bench flips the stored parity bit by hierarchical deposit;
  - read addr 2 → outs=0x0F, vld=1, perr=1;
  - reading an untouched address gives perr=0.
